// File: rtl/pong_video_pkg.sv
// ============================================================================
// Module : pong_video_pkg
// Brief  : Shared timing constants for the Pong horizontal/vertical stages.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pong_video_pkg;

    localparam int unsigned H_TOTAL      = 455;
    localparam int unsigned H_BLANK_END  = 80;
    localparam int unsigned H_SYNC_START = 32;
    localparam int unsigned H_SYNC_END   = 64;
    localparam int unsigned H_CNT_W      = 9;

    localparam int unsigned V_TOTAL      = 262;
    localparam int unsigned V_BLANK_END  = 16;
    localparam int unsigned V_SYNC_START = 4;
    localparam int unsigned V_SYNC_END   = 8;
    localparam int unsigned V_CNT_W      = 9;

    // Ordering every timing stage must satisfy so windows nest and the count fits.
    function automatic bit timing_legal(
        input int unsigned total,
        input int unsigned blank_end,
        input int unsigned sync_start,
        input int unsigned sync_end,
        input int unsigned cnt_w
    );
        return (sync_start < sync_end) && (sync_end <= blank_end) &&
               (blank_end < total) && (total <= (32'd1 << cnt_w));
    endfunction

endpackage

`default_nettype wire

// File: rtl/h_window.sv
// ============================================================================
// Module : h_window
// Brief  : Registered in-window flag decoded from the counter's next value.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module h_window
    import pong_video_pkg::*;
#(
    parameter int unsigned            CNT_W     = H_CNT_W,
    parameter logic [CNT_W-1:0]       WIN_START = '0,
    parameter logic [CNT_W-1:0]       WIN_END   = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cnt_d,
    output logic             in_win
);

    // Reset count is 0, so the flag resets to whether 0 lies in the window.
    localparam logic RST_VAL = (WIN_START == '0) && (WIN_END != '0);

    logic in_win_d;
    logic in_win_q;

    if (WIN_START == '0) begin : g_from_zero
        always_comb begin
            in_win_d = (cnt_d < WIN_END);
        end
    end else begin : g_from_start
        always_comb begin
            in_win_d = (cnt_d >= WIN_START) && (cnt_d < WIN_END);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_win_q <= RST_VAL;
        end else begin
            in_win_q <= in_win_d;
        end
    end

    assign in_win = in_win_q;

endmodule

`default_nettype wire

// File: rtl/hcounter_sync.sv
// ============================================================================
// Module : hcounter_sync
// Brief  : Pong horizontal counter with registered hblank/hsync/hreset.
//          Optional clock enable port when HCOUNTER_SYNC_CE_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hcounter_sync
    import pong_video_pkg::*;
#(
    parameter int unsigned HTOTAL      = H_TOTAL,
    parameter int unsigned HBLANK_END  = H_BLANK_END,
    parameter int unsigned HSYNC_START = H_SYNC_START,
    parameter int unsigned HSYNC_END   = H_SYNC_END
) (
    input  logic clk7_159,
    input  logic _reset,
`ifdef HCOUNTER_SYNC_CE_EN
    input  logic ce,
`endif
    output logic h1,
    output logic h2,
    output logic h4,
    output logic h8,
    output logic h16,
    output logic h32,
    output logic h64,
    output logic h128,
    output logic h256,
    output logic _h256,
    output logic hreset,
    output logic _hreset,
    output logic hblank,
    output logic _hblank,
    output logic hsync,
    output logic _hsync
);

    if (!timing_legal(HTOTAL, HBLANK_END, HSYNC_START, HSYNC_END, H_CNT_W)) begin : g_param_check
        $fatal(1, "hcounter_sync: illegal horizontal timing parameters");
    end

    localparam logic [H_CNT_W-1:0] LAST = H_CNT_W'(HTOTAL - 1);

    logic               ce_en;
    logic [H_CNT_W-1:0] hcnt_q;
    logic [H_CNT_W-1:0] hcnt_d;
    logic [H_CNT_W-1:0] hcnt_adv;
    logic               hreset_q;
    logic               hreset_d;
    logic               hblank_w;
    logic               hsync_w;

`ifdef HCOUNTER_SYNC_CE_EN
    assign ce_en = ce;
`else
    assign ce_en = 1'b1;
`endif

    // Flags decode hcnt_d so each lands in the same cycle as the count it describes;
    // the >= also flushes any out-of-range count back to 0.
    always_comb begin
        hcnt_adv = (hcnt_q >= LAST) ? '0 : hcnt_q + 1'b1;
        hcnt_d   = ce_en ? hcnt_adv : hcnt_q;
        hreset_d = (hcnt_d == LAST);
    end

    always_ff @(posedge clk7_159 or negedge _reset) begin
        if (!_reset) begin
            hcnt_q   <= '0;
            hreset_q <= 1'b0;
        end else begin
            hcnt_q   <= hcnt_d;
            hreset_q <= hreset_d;
        end
    end

    h_window #(
        .CNT_W     (H_CNT_W),
        .WIN_START ('0),
        .WIN_END   (H_CNT_W'(HBLANK_END))
    ) u_blank_win (
        .clk    (clk7_159),
        .rst_n  (_reset),
        .cnt_d  (hcnt_d),
        .in_win (hblank_w)
    );

    h_window #(
        .CNT_W     (H_CNT_W),
        .WIN_START (H_CNT_W'(HSYNC_START)),
        .WIN_END   (H_CNT_W'(HSYNC_END))
    ) u_sync_win (
        .clk    (clk7_159),
        .rst_n  (_reset),
        .cnt_d  (hcnt_d),
        .in_win (hsync_w)
    );

    assign {h256, h128, h64, h32, h16, h8, h4, h2, h1} = hcnt_q;
    assign _h256   = ~hcnt_q[8];
    assign hreset  = hreset_q;
    assign _hreset = ~hreset_q;
    assign hblank  = hblank_w;
    assign _hblank = ~hblank_w;
    assign hsync   = hsync_w;
    assign _hsync  = ~hsync_w;

endmodule

`default_nettype wire

// File: tb/tb_hcounter_sync.sv
// ============================================================================
// Module : tb_hcounter_sync
// Brief  : Scoreboard bench for hcounter_sync (ce tests need HCOUNTER_SYNC_CE_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hcounter_sync;

    localparam int CLK_HALF = 5;
    localparam int CLK_PER  = 10;
    localparam int LINE     = 455;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic ce_drv = 1'b1;

    logic h1, h2, h4, h8, h16, h32, h64, h128, h256, _h256;
    logic hreset, _hreset, hblank, _hblank, hsync, _hsync;
    logic [15:0] act;

    logic [15:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          m_cnt  = 0;
    int          vcnt   = 0;
    time         last_rise = 0;
    time         prev_rise = 0;
    event        sample_ev;

    always #CLK_HALF clk = ~clk;

    hcounter_sync dut (
        .clk7_159 (clk),
        ._reset   (rst_n),
`ifdef HCOUNTER_SYNC_CE_EN
        .ce       (ce_drv),
`endif
        .h1       (h1),
        .h2       (h2),
        .h4       (h4),
        .h8       (h8),
        .h16      (h16),
        .h32      (h32),
        .h64      (h64),
        .h128     (h128),
        .h256     (h256),
        ._h256    (_h256),
        .hreset   (hreset),
        ._hreset  (_hreset),
        .hblank   (hblank),
        ._hblank  (_hblank),
        .hsync    (hsync),
        ._hsync   (_hsync)
    );

    assign act = {h256, h128, h64, h32, h16, h8, h4, h2, h1,
                  hreset, hblank, hsync, _h256, _hreset, _hblank, _hsync};

    // Expected outputs for a given count, straight from the timing table.
    function automatic logic [15:0] expect_of(input int c);
        logic [8:0] cv;
        logic hr, hb, hs;
        cv = c[8:0];
        hr = (c == 454);
        hb = (c < 80);
        hs = (c >= 32) && (c < 64);
        return {cv, hr, hb, hs, ~cv[8], ~hr, ~hb, ~hs};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n && ce_drv) m_cnt = (m_cnt == LINE - 1) ? 0 : m_cnt + 1;
        #1;
        exp_q.push_back(expect_of(m_cnt));
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        m_cnt = 0;
        #1;
        exp_q.push_back(expect_of(0));
        ->sample_ev;
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 2 * LINE && m_cnt != target; i++) tick();
    endtask

    task automatic check_val(input string name, input longint actual, input longint req);
        checks++;
        if (actual != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, req);
        end
    endtask

    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk or sample_ev);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL line_state t=%0t actual={cnt=%0d hr=%b hb=%b hs=%b inv=%b} required={cnt=%0d hr=%b hb=%b hs=%b inv=%b}",
                             $time, act[15:7], act[6], act[5], act[4], act[3:0],
                             e[15:7], e[6], e[5], e[4], e[3:0]);
                end
            end
        end
    end

    initial forever begin
        @(posedge hreset);
        prev_rise = last_rise;
        last_rise = $time;
    end

    // Model vertical stage: advances on each falling edge of hreset.
    initial forever begin
        @(negedge hreset);
        vcnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0;

        #1 rst_n = 1'b0;
        repeat (10) tick();
        #2 rst_n = 1'b1;
        v0 = vcnt;

        repeat (3 * LINE) tick();
        check_val("hreset_period", longint'(last_rise - prev_rise), longint'(LINE * CLK_PER));
        check_val("vcount_lines", vcnt - v0, 3);

        run_to(453);
        #6 async_reset();
        repeat (2) tick();
        #2 rst_n = 1'b1;
        repeat (LINE) tick();

        run_to(454);
        #6 async_reset();
        repeat (2) tick();
        #2 rst_n = 1'b1;
        repeat (LINE) tick();

`ifdef HCOUNTER_SYNC_CE_EN
        for (int i = 0; i < 2 * LINE; i++) begin
            ce_drv = (i % 2 == 0);
            tick();
        end
        ce_drv = 1'b1;
        run_to(40);
        ce_drv = 1'b0;
        repeat (20) tick();
        ce_drv = 1'b1;
        repeat (50) tick();
`endif

        @(negedge clk);
        #1;
        check_val("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hcounter_sync.md
Name: hcounter_sync

Overview:
- Horizontal timing stage of the Pong video chain.
- Runs on the 7.159 MHz pixel clock and produces the horizontal count bits h1..h256.
- Generates hblank and hsync, plus the one-clock hreset pulse that clocks the downstream vertical counter (which advances on the falling edge of hreset).
- All outputs come straight from flops, so the downstream edge-triggered logic never sees decode glitches.

Parameters:
- HTOTAL, 455: clocks per line; count runs 0..HTOTAL-1 (0..454).
- HBLANK_END, 80: first visible count; hblank is high for counts 0..HBLANK_END-1.
- HSYNC_START, 32: first count with hsync high.
- HSYNC_END, 64: first count after the sync pulse; hsync is high for 32..63.

Ports:
- clk7_159  in  1  pixel clock; all state changes on its rising edge.
- _reset  in  1  asynchronous, active-low reset.
- h1, h2, h4, h8, h16, h32, h64, h128, h256  out  1 each  count bits 0..8.
- _h256  out  1  inverse of h256.
- hreset, _hreset  out  1 each  end-of-line pulse and its inverse.
- hblank, _hblank  out  1 each  horizontal blank and its inverse.
- hsync, _hsync  out  1 each  horizontal sync (active high) and its inverse.

Behaviour:
- Reset: with _reset low, asynchronously:
  - hcnt=0, hreset=0, hblank=1, hsync=0.
  - Inverted outputs are their complements: _h256=1, _hreset=1, _hblank=0, _hsync=1.
- Counter:
  - hcnt_next = (hcnt==HTOTAL-1) ? 0 : hcnt+1, 9-bit unsigned.
  - Wraps 454 -> 0; values 455..511 are never reached.
  - Any illegal value present after an upset goes to 0 on the next clock.
- Flag flops: hreset, hblank and hsync are each registered from a decode of hcnt_next, so each flag lines up exactly with the hcnt value it describes (zero lag).
  - hreset = 1 only while hcnt==454. It is exactly one clock wide, and its falling edge coincides with the wrap to 0.
  - hblank = 1 while hcnt < HBLANK_END.
  - hsync = 1 while HSYNC_START <= hcnt < HSYNC_END, which is fully inside hblank.
- Line period: 455 clocks; hreset rising edges are exactly 455 clocks apart.
- Deassertion of _reset: counting starts on the first rising edge after release (hcnt 0 -> 1). The first hreset pulse follows 454 clocks after release.
- Reset mid-line: all state returns immediately to the reset values. A pending hreset is killed at once (a falling edge of hreset may therefore occur early); downstream must tolerate this.
- Parameter legality (elaboration check, fatal if violated): HSYNC_START < HSYNC_END <= HBLANK_END < HTOTAL <= 512.

Optional Feature:
- Macro: HCOUNTER_SYNC_CE_EN.
- Defined:
  - Adds input port ce (1 bit, placed after _reset).
  - hcnt and all flag flops update only on clocks where ce==1; when ce==0 everything holds its value.
  - hreset stays high for as many clocks as ce is low while hcnt==454.
- Undefined: no ce port; behaves as if ce were tied to 1.

Decomposition:
- Shared package pong_video_pkg holds:
  - localparams H_TOTAL=455, H_BLANK_END=80, H_SYNC_START=32, H_SYNC_END=64, H_CNT_W=9.
  - V_TOTAL=262 and the vertical-side constants, so the vertical stage shares the same source.
- One natural sub-module: h_window.
  - Inputs: the next-count value and START/END parameters.
  - Output: a registered in-window flag with asynchronous active-low reset.
  - Instantiated twice: blank window (0..79) and sync window (32..63).

Test Plan:
- Reset hold: drive _reset=0 for 10 clocks, then release -> during reset hcnt=0, hblank=1, hsync=0, hreset=0; on the first edge after release the count goes 0 -> 1.
- Full line: run 455 clocks from count 0 ->
  - hreset is high exactly while count==454.
  - Count returns to 0 on clock 455.
  - {h256..h1} match the count every cycle; _h256 == ~h256.
- Windows: over one line ->
  - hblank is high on counts 0..79 and drops at 80.
  - hsync rises at 32 and falls at 64.
  - hsync is never high while hblank is low.
- Period: run 3 lines -> hreset rising edges are exactly 455 clocks apart. A model vertical counter on negedge hreset increments once per line.
- Mid-line reset: assert _reset asynchronously (not on a clock edge) at count 453, and separately at count 454 with hreset high -> outputs return to reset values within the same cycle; after release the next line is a full 455 clocks.
- With HCOUNTER_SYNC_CE_EN: toggle ce 1,0,1,0… -> the line takes 910 clocks and hreset is high for 2 clocks. Hold ce=0 at count 40 for 20 clocks -> hsync and hblank stay high and the count stays 40.
